// File: rtl/debug_arb_pkg.sv
// ---------------------------------------------------------------------------
// debug_arb_pkg
//   Shared definitions for the debug bus arbiter:
//     - run_state_e          : CPU run-control states
//     - RW_READ / RW_WRITE   : bus rw encoding (1 = read, 0 = write)
//     - VALUE_ID_*           : debugger value-port register ids
//     - CTRL_*_BIT           : CONTROL register bit positions
//     - control_word()       : builds the CONTROL read-back word
// ---------------------------------------------------------------------------
package debug_arb_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2,
    STEP      = 2'd3
  } run_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [15:0] VALUE_ID_CONTROL     = 16'h0000;
  localparam logic [15:0] VALUE_ID_INSTR_COUNT = 16'h0001;

  // Write view of CONTROL
  localparam int CTRL_HALT_BIT   = 0;
  localparam int CTRL_STEP_BIT   = 1;
  // Read view of CONTROL: bit1 reports the halted status instead of step
  localparam int CTRL_HALTED_BIT = 1;

  function automatic logic [15:0] control_word(input logic halted,
                                               input logic halt_req);
    logic [15:0] w;
    w                  = '0;
    w[CTRL_HALT_BIT]   = halt_req;
    w[CTRL_HALTED_BIT] = halted;
    return w;
  endfunction

endpackage

// File: rtl/debug_run_control.sv
// ---------------------------------------------------------------------------
// debug_run_control
//   CPU run-control state machine (RUN / HALT_PEND / HALTED / STEP) and the
//   retired-opcode counter INSTR_COUNT.
//   Ports:
//     i_clk, i_reset        clock, synchronous active-high reset
//     i_ctrl_wr             CONTROL write strobe (decoded value port)
//     i_ctrl_halt/step      CONTROL write data bits
//     i_cpu_sync            CPU presents an opcode fetch this cycle
//     i_steal               debugger owns (or just owned) the memory port
//     o_run_ce              run-control clock enable (before steal gating)
//     o_halted              frozen at an opcode boundary
//     o_halt_req            last written halt bit
//     o_instr_count         INSTR_COUNT (value before this cycle's increment)
// ---------------------------------------------------------------------------
module debug_run_control
  import debug_arb_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ctrl_wr,
  input  logic        i_ctrl_halt,
  input  logic        i_ctrl_step,
  input  logic        i_cpu_sync,
  input  logic        i_steal,
  output logic        o_run_ce,
  output logic        o_halted,
  output logic        o_halt_req,
  output logic [15:0] o_instr_count
);

  run_state_e  state_q, state_d;
  logic        stepped_q, stepped_d;
  logic        halt_req_q, halt_req_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        run_ce;
  logic        ce_eff;

  // A fetch is only captured (halt) on a cycle the CPU would really have
  // clocked; a stolen cycle leaves the fetch pending for a later sync.
  always_comb begin
    state_d = state_q;
    run_ce  = 1'b1;
    case (state_q)
      RUN: begin
        if (i_ctrl_wr && i_ctrl_halt) state_d = HALT_PEND;
      end
      HALT_PEND: begin
        if (i_ctrl_wr && !i_ctrl_halt) begin
          state_d = RUN;
        end else if (i_cpu_sync && !i_steal) begin
          run_ce  = 1'b0;
          state_d = HALTED;
        end
      end
      HALTED: begin
        run_ce = 1'b0;
        if (i_ctrl_wr && i_ctrl_step)       state_d = STEP;
        else if (i_ctrl_wr && !i_ctrl_halt) state_d = RUN;
      end
      STEP: begin
        // The first sync in STEP is the held fetch and must execute; only a
        // sync after at least one real clock ends the step.
        if (i_cpu_sync && stepped_q && !i_steal) begin
          run_ce  = 1'b0;
          state_d = HALTED;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign ce_eff = run_ce & ~i_steal;

  always_comb begin
    stepped_d     = (state_q == STEP) && (stepped_q || ce_eff);
    halt_req_d    = i_ctrl_wr ? i_ctrl_halt : halt_req_q;
    instr_count_d = instr_count_q;
    if (ce_eff && i_cpu_sync) instr_count_d = instr_count_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= RUN;
      stepped_q     <= 1'b0;
      halt_req_q    <= 1'b0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      stepped_q     <= stepped_d;
      halt_req_q    <= halt_req_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign o_run_ce      = run_ce;
  assign o_halted      = (state_q == HALTED);
  assign o_halt_req    = halt_req_q;
  assign o_instr_count = instr_count_q;

endmodule

// File: rtl/debug_bus_arbiter.sv
// ---------------------------------------------------------------------------
// debug_bus_arbiter
//   Shares the synchronous RAM port between the 6502 core and the debugger
//   (debugger always wins) and owns CPU run control.
//   Ports:
//     i_clk, i_reset                       clock, synchronous active-high reset
//     i_dbg_address/rw/en/data, o_dbg_data debugger memory port
//     i_value_id/rw/en/data, o_value_data  debugger value port (CONTROL,
//                                          INSTR_COUNT)
//     i_cpu_address/rw/data, i_cpu_sync    CPU bus request
//     o_cpu_data, o_cpu_ce                 CPU read data and clock enable
//     o_mem_address/rw/en/data, i_mem_data RAM port (read data one cycle
//                                          after en)
//     o_halted                             CPU frozen at an opcode boundary
// ---------------------------------------------------------------------------
module debug_bus_arbiter
  import debug_arb_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_dbg_address,
  input  logic        i_dbg_rw,
  input  logic        i_dbg_en,
  input  logic [7:0]  i_dbg_data,
  output logic [7:0]  o_dbg_data,
  input  logic [15:0] i_value_id,
  input  logic        i_value_rw,
  input  logic        i_value_en,
  input  logic [15:0] i_value_data,
  output logic [15:0] o_value_data,
  input  logic [15:0] i_cpu_address,
  input  logic        i_cpu_rw,
  input  logic [7:0]  i_cpu_data,
  input  logic        i_cpu_sync,
  output logic [7:0]  o_cpu_data,
  output logic        o_cpu_ce,
  output logic [15:0] o_mem_address,
  output logic        o_mem_rw,
  output logic        o_mem_en,
  output logic [7:0]  o_mem_data,
  input  logic [7:0]  i_mem_data,
  output logic        o_halted
);

  logic        steal_q, steal_d, steal;
  logic        dbg_rd_pend_q, dbg_rd_pend_d;
  logic        cpu_rd_pend_q, cpu_rd_pend_d;
  logic [7:0]  dbg_hold_q, dbg_hold_d;
  logic [7:0]  cpu_hold_q, cpu_hold_d;
  logic        ctrl_wr, ctrl_halt, ctrl_step, value_rd;
  logic        run_ce, halted, halt_req;
  logic [15:0] instr_count;
  logic        cpu_ce;
  logic        value_data_unused;

  // The CPU is held in the grant cycle and the one after, so the RAM output
  // the debugger samples is not disturbed by a CPU access.
  assign steal_d = i_dbg_en;
  assign steal   = i_dbg_en | steal_q;

  assign ctrl_wr   = i_value_en && (i_value_rw == RW_WRITE) &&
                     (i_value_id == VALUE_ID_CONTROL);
  assign ctrl_halt = i_value_data[CTRL_HALT_BIT];
  assign ctrl_step = i_value_data[CTRL_STEP_BIT];
  assign value_rd  = i_value_en && (i_value_rw == RW_READ);
  assign value_data_unused = ^i_value_data[15:2];

  debug_run_control u_run_control (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_ctrl_wr     (ctrl_wr),
    .i_ctrl_halt   (ctrl_halt),
    .i_ctrl_step   (ctrl_step),
    .i_cpu_sync    (i_cpu_sync),
    .i_steal       (steal),
    .o_run_ce      (run_ce),
    .o_halted      (halted),
    .o_halt_req    (halt_req),
    .o_instr_count (instr_count)
  );

  assign cpu_ce = run_ce & ~steal;

  // While reset is held the port is parked idle and the CPU is left enabled.
  assign o_cpu_ce = i_reset ? 1'b1 : cpu_ce;
  assign o_halted = i_reset ? 1'b0 : halted;

  always_comb begin
    o_mem_address = '0;
    o_mem_rw      = RW_READ;
    o_mem_en      = 1'b0;
    o_mem_data    = '0;
    if (!i_reset) begin
      if (i_dbg_en) begin
        o_mem_address = i_dbg_address;
        o_mem_rw      = i_dbg_rw;
        o_mem_en      = 1'b1;
        if (i_dbg_rw == RW_WRITE) o_mem_data = i_dbg_data;
      end else begin
        o_mem_address = i_cpu_address;
        o_mem_rw      = i_cpu_rw;
        o_mem_en      = cpu_ce;
        if (i_cpu_rw == RW_WRITE) o_mem_data = i_cpu_data;
      end
    end
  end

  // Read return: RAM data is live the cycle after a read grant, and is
  // captured then so the requester keeps seeing it afterwards.
  always_comb begin
    dbg_rd_pend_d = i_dbg_en && (i_dbg_rw == RW_READ);
    cpu_rd_pend_d = !i_dbg_en && cpu_ce && (i_cpu_rw == RW_READ);
    dbg_hold_d    = dbg_rd_pend_q ? i_mem_data : dbg_hold_q;
    cpu_hold_d    = cpu_rd_pend_q ? i_mem_data : cpu_hold_q;
  end

  assign o_dbg_data = dbg_rd_pend_q ? i_mem_data : dbg_hold_q;
  assign o_cpu_data = cpu_rd_pend_q ? i_mem_data : cpu_hold_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      steal_q       <= 1'b0;
      dbg_rd_pend_q <= 1'b0;
      cpu_rd_pend_q <= 1'b0;
      dbg_hold_q    <= '0;
      cpu_hold_q    <= '0;
    end else begin
      steal_q       <= steal_d;
      dbg_rd_pend_q <= dbg_rd_pend_d;
      cpu_rd_pend_q <= cpu_rd_pend_d;
      dbg_hold_q    <= dbg_hold_d;
      cpu_hold_q    <= cpu_hold_d;
    end
  end

  always_comb begin
    o_value_data = '0;
    if (value_rd) begin
      if (i_value_id == VALUE_ID_CONTROL)          o_value_data = control_word(halted, halt_req);
      else if (i_value_id == VALUE_ID_INSTR_COUNT) o_value_data = instr_count;
    end
  end

endmodule

// File: tb/tb_debug_bus_arbiter.sv
module tb_debug_bus_arbiter;
  import debug_arb_pkg::*;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_dbg_address;
  logic        i_dbg_rw, i_dbg_en;
  logic [7:0]  i_dbg_data;
  logic [7:0]  o_dbg_data;
  logic [15:0] i_value_id;
  logic        i_value_rw, i_value_en;
  logic [15:0] i_value_data;
  logic [15:0] o_value_data;
  logic [15:0] i_cpu_address;
  logic        i_cpu_rw;
  logic [7:0]  i_cpu_data;
  logic        i_cpu_sync;
  logic [7:0]  o_cpu_data;
  logic        o_cpu_ce;
  logic [15:0] o_mem_address;
  logic        o_mem_rw, o_mem_en;
  logic [7:0]  o_mem_data;
  logic [7:0]  i_mem_data;
  logic        o_halted;

  always #5 clk = ~clk;

  debug_bus_arbiter dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_dbg_address(i_dbg_address), .i_dbg_rw(i_dbg_rw), .i_dbg_en(i_dbg_en),
    .i_dbg_data(i_dbg_data), .o_dbg_data(o_dbg_data),
    .i_value_id(i_value_id), .i_value_rw(i_value_rw), .i_value_en(i_value_en),
    .i_value_data(i_value_data), .o_value_data(o_value_data),
    .i_cpu_address(i_cpu_address), .i_cpu_rw(i_cpu_rw), .i_cpu_data(i_cpu_data),
    .i_cpu_sync(i_cpu_sync), .o_cpu_data(o_cpu_data), .o_cpu_ce(o_cpu_ce),
    .o_mem_address(o_mem_address), .o_mem_rw(o_mem_rw), .o_mem_en(o_mem_en),
    .o_mem_data(o_mem_data), .i_mem_data(i_mem_data), .o_halted(o_halted)
  );

  // Synchronous RAM model: read data valid the cycle after en.
  bit   [7:0] ram [0:65535];
  logic [7:0] ram_rdata = 8'h00;
  always @(posedge clk) begin
    if (o_mem_en === 1'b1) begin
      if (o_mem_rw == RW_WRITE) ram[o_mem_address] <= o_mem_data;
      else                      ram_rdata <= ram[o_mem_address];
    end
  end
  assign i_mem_data = ram_rdata;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    i_dbg_address = '0; i_dbg_rw = RW_READ; i_dbg_en = 1'b0; i_dbg_data = '0;
    i_value_id = '0; i_value_rw = RW_READ; i_value_en = 1'b0; i_value_data = '0;
    i_cpu_address = '0; i_cpu_rw = RW_READ; i_cpu_data = '0; i_cpu_sync = 1'b0;
  endtask

  task automatic value_wr(input logic [15:0] id, input logic [15:0] data);
    i_value_en = 1'b1; i_value_rw = RW_WRITE; i_value_id = id; i_value_data = data;
  endtask

  task automatic value_rd(input logic [15:0] id, output logic [15:0] data);
    i_value_en = 1'b1; i_value_rw = RW_READ; i_value_id = id;
    #1;
    data = o_value_data;
    i_value_en = 1'b0;
  endtask

  typedef struct {
    logic        dbg_en;
    logic        dbg_rw;
    logic [15:0] dbg_addr;
    logic [7:0]  dbg_wdata;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_wdata;
    logic [15:0] e_addr;
    logic        e_rw;
    logic        e_en;
    logic [7:0]  e_data;
    logic        e_ce;
  } vec_t;

  vec_t        vecs [8];
  logic [15:0] rv;
  int          ce_low;
  logic [4:0]  ce_pat;
  logic [4:0]  halt_pat;
  logic        ce_seen;

  initial begin
    // Back-to-back sequence in RUN; expected ce accounts for the steal tail.
    vecs[0] = '{1'b0, 1'b1, 16'h0000, 8'h00, 16'h1000, 1'b1, 8'h99, 16'h1000, 1'b1, 1'b1, 8'h00, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 8'h00, 16'h2000, 1'b0, 8'h77, 16'h2000, 1'b0, 1'b1, 8'h77, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 16'h1234, 8'hEE, 16'h2000, 1'b0, 8'h77, 16'h1234, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 16'h0000, 8'h00, 16'h2000, 1'b0, 8'h77, 16'h2000, 1'b0, 1'b0, 8'h77, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h0300, 8'h3C, 16'h1000, 1'b1, 8'h00, 16'h0300, 1'b0, 1'b1, 8'h3C, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 16'h0301, 8'hC3, 16'h1000, 1'b1, 8'h00, 16'h0301, 1'b0, 1'b1, 8'hC3, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 16'h0000, 8'h00, 16'h1000, 1'b1, 8'h00, 16'h1000, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 16'h0000, 8'h00, 16'h1001, 1'b1, 8'h00, 16'h1001, 1'b1, 1'b1, 8'h00, 1'b1};

    ram[16'h1234] = 8'h5A;
    ram[16'h0100] = 8'h22;

    idle();
    i_reset = 1'b1;
    tick();
    sample();
    chk("reset_ce",     32'(o_cpu_ce), 32'h1);
    chk("reset_halted", 32'(o_halted), 32'h0);
    chk("reset_mem",    32'({o_mem_address, o_mem_rw, o_mem_en, o_mem_data}), 32'({16'h0000, 1'b1, 1'b0, 8'h00}));
    chk("reset_rdata",  32'({o_dbg_data, o_cpu_data}), 32'h0);
    chk("reset_value",  32'(o_value_data), 32'h0);
    tick();
    i_reset = 1'b0;

    // Table-driven port ownership / stall vectors
    for (int i = 0; i < 8; i++) begin
      i_dbg_en = vecs[i].dbg_en; i_dbg_rw = vecs[i].dbg_rw;
      i_dbg_address = vecs[i].dbg_addr; i_dbg_data = vecs[i].dbg_wdata;
      i_cpu_address = vecs[i].cpu_addr; i_cpu_rw = vecs[i].cpu_rw; i_cpu_data = vecs[i].cpu_wdata;
      sample();
      chk($sformatf("vec%0d", i),
          32'({o_mem_address, o_mem_rw, o_mem_en, o_mem_data, o_cpu_ce}),
          32'({vecs[i].e_addr, vecs[i].e_rw, vecs[i].e_en, vecs[i].e_data, vecs[i].e_ce}));
      tick();
    end
    idle();

    // Debugger read steal while the CPU reads 0x0100
    ce_low = 0;
    i_cpu_address = 16'h0100;
    sample(); if (!o_cpu_ce) ce_low++;
    tick();
    i_dbg_en = 1'b1; i_dbg_rw = RW_READ; i_dbg_address = 16'h1234;
    sample(); if (!o_cpu_ce) ce_low++;
    chk("steal_grant_addr", 32'(o_mem_address), 32'h1234);
    tick();
    i_dbg_en = 1'b0;
    sample(); if (!o_cpu_ce) ce_low++;
    chk("steal_rdata", 32'(o_dbg_data), 32'h5A);
    tick();
    sample(); if (!o_cpu_ce) ce_low++;
    chk("cpu_resume", 32'({o_mem_address, o_mem_en, o_dbg_data}), 32'({16'h0100, 1'b1, 8'h5A}));
    tick();
    sample(); if (!o_cpu_ce) ce_low++;
    chk("cpu_rdata", 32'(o_cpu_data), 32'h22);
    chk("steal_len", 32'(ce_low), 32'd2);
    tick();

    // Halt request, sync on the third cycle
    value_wr(VALUE_ID_CONTROL, 16'h0001);
    tick();
    i_value_en = 1'b0;
    sample();
    chk("hp_ce", 32'({o_cpu_ce, o_halted}), 32'b10);
    value_rd(VALUE_ID_CONTROL, rv);
    chk("hp_ctrl", 32'(rv), 32'h0001);
    tick();
    tick();
    i_cpu_sync = 1'b1;
    sample();
    chk("hp_sync_ce", 32'({o_cpu_ce, o_halted}), 32'b00);
    tick();
    sample();
    chk("halted", 32'({o_cpu_ce, o_halted}), 32'b01);
    value_rd(VALUE_ID_CONTROL, rv);
    chk("halted_ctrl", 32'(rv), 32'h0003);
    value_rd(VALUE_ID_INSTR_COUNT, rv);
    chk("halted_count", 32'(rv), 32'h0000);
    tick();

    // Single step of a 4-cycle instruction
    value_wr(VALUE_ID_CONTROL, 16'h0003);
    tick();
    i_value_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      i_cpu_sync = (k == 0 || k == 4);
      sample();
      ce_pat[k]   = o_cpu_ce;
      halt_pat[k] = o_halted;
      tick();
    end
    chk("step_ce_pat", 32'(ce_pat), 32'b01111);
    chk("step_halt_pat", 32'(halt_pat), 32'b00000);
    sample();
    chk("step_rehalted", 32'({o_cpu_ce, o_halted}), 32'b01);
    value_rd(VALUE_ID_INSTR_COUNT, rv);
    chk("step_count", 32'(rv), 32'h0001);
    tick();

    // Debugger write/read while halted; CPU must stay frozen
    ce_seen = 1'b0;
    i_dbg_en = 1'b1; i_dbg_rw = RW_WRITE; i_dbg_address = 16'h0200; i_dbg_data = 8'hA5;
    sample(); ce_seen |= o_cpu_ce;
    chk("h_wr_port", 32'({o_mem_address, o_mem_rw, o_mem_en, o_mem_data}), 32'({16'h0200, 1'b0, 1'b1, 8'hA5}));
    tick();
    i_dbg_rw = RW_READ; i_dbg_data = 8'h00;
    sample(); ce_seen |= o_cpu_ce;
    tick();
    i_dbg_en = 1'b0;
    sample(); ce_seen |= o_cpu_ce;
    chk("h_rd_data", 32'(o_dbg_data), 32'hA5);
    tick();
    sample(); ce_seen |= o_cpu_ce;
    chk("h_ram_written", 32'(ram[16'h0200]), 32'hA5);
    chk("h_ce_never", 32'(ce_seen), 32'h0);
    tick();

    // Resume
    i_cpu_sync = 1'b0;
    value_wr(VALUE_ID_CONTROL, 16'h0000);
    tick();
    i_value_en = 1'b0;
    sample();
    chk("resume", 32'({o_cpu_ce, o_halted}), 32'b10);
    value_rd(VALUE_ID_CONTROL, rv);
    chk("resume_ctrl", 32'(rv), 32'h0000);
    tick();

    // INSTR_COUNT wrap
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    i_cpu_sync = 1'b1;
    for (int n = 0; n < 65534; n++) tick();
    sample();
    value_rd(VALUE_ID_INSTR_COUNT, rv);
    chk("count_pre_inc", 32'(rv), 32'hFFFE);
    tick();
    i_cpu_sync = 1'b0;
    sample();
    value_rd(VALUE_ID_INSTR_COUNT, rv);
    chk("count_max", 32'(rv), 32'hFFFF);
    tick();
    i_cpu_sync = 1'b1;
    tick();
    i_cpu_sync = 1'b0;
    sample();
    value_rd(VALUE_ID_INSTR_COUNT, rv);
    chk("count_wrap", 32'(rv), 32'h0000);
    tick();

    // Reset during a stalled STEP
    value_wr(VALUE_ID_CONTROL, 16'h0001);
    tick();
    i_value_en = 1'b0;
    i_cpu_sync = 1'b1;
    tick();
    value_wr(VALUE_ID_CONTROL, 16'h0003);
    tick();
    i_value_en = 1'b0;
    i_dbg_en = 1'b1; i_dbg_rw = RW_READ; i_dbg_address = 16'h1234;
    sample();
    chk("step_steal", 32'({o_cpu_ce, o_halted}), 32'b00);
    tick();
    idle();
    i_cpu_address = 16'h4444;
    i_reset = 1'b1;
    tick();
    sample();
    chk("rst_step_ctl", 32'({o_cpu_ce, o_halted}), 32'b10);
    chk("rst_step_mem", 32'({o_mem_address, o_mem_rw, o_mem_en, o_mem_data}), 32'({16'h0000, 1'b1, 1'b0, 8'h00}));
    chk("rst_step_rdata", 32'({o_dbg_data, o_cpu_data}), 32'h0);
    value_rd(VALUE_ID_CONTROL, rv);
    chk("rst_step_value", 32'(rv), 32'h0000);
    tick();
    i_reset = 1'b0;
    sample();
    chk("post_rst_ce", 32'({o_cpu_ce, o_mem_en, o_halted}), 32'b110);
    value_rd(VALUE_ID_INSTR_COUNT, rv);
    chk("post_rst_count", 32'(rv), 32'h0000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
